// File: rtl/red_seq_ctrl.sv
// red_seq_ctrl: multi-cycle sequencer for the RED reduction.
// Two 16-bit operands are latched on an accepted start and split into four
// signed 4-bit nibbles each. One nibble pair per cycle is folded into a
// 7-bit signed accumulator. The sign-extended 16-bit sum is published on S
// together with a one-cycle done pulse. The 7-bit accumulator covers the full
// range -64..+56, so no saturation is needed.
module red_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic        stall,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] S
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic signed [6:0]  acc_q, acc_d;
    logic [15:0]        op_a_q, op_a_d;
    logic [15:0]        op_b_q, op_b_d;
    logic signed [15:0] s_q, s_d;
    logic signed [6:0]  step_sum;

    // Pick nibble idx out of a 16-bit word; idx 0 is the least significant.
    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] i);
        logic [3:0] r;
        case (i)
            2'd0:    r = w[3:0];
            2'd1:    r = w[7:4];
            2'd2:    r = w[11:8];
            default: r = w[15:12];
        endcase
        return r;
    endfunction

    // Sign-extend a 4-bit two's complement nibble to the accumulator width.
    function automatic logic signed [6:0] sx7(input logic [3:0] n);
        return {{3{n[3]}}, n};
    endfunction

    // Sign-extend the final accumulator value to the 16-bit result.
    function automatic logic signed [15:0] sx16(input logic signed [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

    // Accumulator plus the current nibble pair of the latched operands.
    always_comb begin
        step_sum = acc_q + sx7(nib(op_a_q, idx_q)) + sx7(nib(op_b_q, idx_q));
    end

    // Next-state logic: accept, accumulate, publish; flush beats stall beats start.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = ACC;
                    op_a_d  = A;
                    op_b_d  = B;
                    acc_d   = 7'sd0;
                    idx_d   = 2'd0;
                end
            end
            ACC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    acc_d = step_sum;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        s_d     = sx16(step_sum);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // stall is deliberately ignored here: the result is already out.
                if (flush) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = ACC;
                    op_a_d  = A;
                    op_b_d  = B;
                    acc_d   = 7'sd0;
                    idx_d   = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            acc_q   <= 7'sd0;
            s_q     <= 16'sd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
        end
    end

    // Operand registers are pure data and only matter after an accept.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign busy = (state_q == ACC) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign S    = s_q;

endmodule

// File: tb/tb_red_seq_ctrl.sv
// tb_red_seq_ctrl: directed bench for red_seq_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_red_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic        stall;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] S;

    int checks = 0;
    int errors = 0;

    red_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .stall (stall),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full unstalled operation: busy for 5 cycles, done on the 5th, then idle.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_s);
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
            chk({tag, "_done"}, {15'd0, done}, (k == 5) ? 16'd1 : 16'd0);
        end
        chk({tag, "_S"}, S, exp_s);
        step();
        chk({tag, "_busy_after"}, {15'd0, busy}, 16'd0);
        chk({tag, "_done_after"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        A     = 16'h0000;
        B     = 16'h0000;
        step();
        step();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_S", S, 16'h0000);
        rst_n = 1'b1;
        step();
        chk("idle_S", S, 16'h0000);

        // Basic operation
        do_op("ones", 16'h1111, 16'h1111, 16'h0008);

        // Extremes
        do_op("min", 16'h8888, 16'h8888, 16'hFFC0);
        chk("min_signcopy", {6'd0, S[15:6]}, 16'h03FF);
        do_op("max", 16'h7777, 16'h7777, 16'h0038);
        chk("max_signcopy", {6'd0, S[15:6]}, 16'h0000);

        // Mixed-sign nibbles cancel
        do_op("cancel", 16'h00F1, 16'h0000, 16'h0000);

        // Stall for two cycles after idx 1 has been accumulated
        A = 16'h0003;
        B = 16'h0002;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            stall = (k == 3) || (k == 4);
            if (k == 3) begin
                A = 16'hFFFF;
                B = 16'hFFFF;
            end
            chk("stall_busy", {15'd0, busy}, 16'd1);
            chk("stall_done", {15'd0, done}, (k == 7) ? 16'd1 : 16'd0);
        end
        chk("stall_S", S, 16'h0005);
        step();
        chk("stall_busy_after", {15'd0, busy}, 16'd0);

        // Flush during the third ACC cycle
        A = 16'hFFFF;
        B = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {15'd0, busy}, 16'd0);
        chk("flush_done", {15'd0, done}, 16'd0);
        chk("flush_S", S, 16'h0005);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("flush_no_done", {15'd0, done}, 16'd0);
        end
        chk("flush_S_hold", S, 16'h0005);
        do_op("after_flush", 16'h1111, 16'h1111, 16'h0008);

        // Flush in the same cycle as start blocks acceptance
        A = 16'h7777;
        B = 16'h7777;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {15'd0, busy}, 16'd0);
        step();
        chk("flush_start_busy2", {15'd0, busy}, 16'd0);

        // Ignored start during ACC, then back-to-back start in DONE
        A = 16'h1111;
        B = 16'h1111;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy1", {15'd0, busy}, 16'd1);
        step();
        A = 16'hFFFF;
        B = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_ign_done", {15'd0, done}, 16'd0);
        step();
        chk("b2b_done_k4", {15'd0, done}, 16'd0);
        step();
        chk("b2b_done1", {15'd0, done}, 16'd1);
        chk("b2b_S1", S, 16'h0008);
        A = 16'h2222;
        B = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            chk("b2b2_busy", {15'd0, busy}, 16'd1);
            chk("b2b2_done", {15'd0, done}, (k == 5) ? 16'd1 : 16'd0);
        end
        chk("b2b_S2", S, 16'h0008);
        step();
        chk("b2b_busy_after", {15'd0, busy}, 16'd0);

        // Stall has no effect in DONE
        A = 16'h0001;
        B = 16'h0001;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        chk("done_stall_done", {15'd0, done}, 16'd1);
        chk("done_stall_S", S, 16'h0002);
        stall = 1'b1;
        step();
        stall = 1'b0;
        chk("done_stall_busy", {15'd0, busy}, 16'd0);

        // Reset mid-operation
        A = 16'h1111;
        B = 16'h1111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_done", {15'd0, done}, 16'd0);
        chk("midrst_S", S, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("midrst_no_done", {15'd0, done}, 16'd0);
        end
        chk("midrst_S_hold", S, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
